// File: rtl/ex_nor_gate.sv
// Two-input XNOR gate with a registered copy of its output and saturating
// equality statistics, used to monitor agreement between two 1-bit signals.
module ex_nor_gate #(
    parameter int CNT_W = 8
) (
    output logic             Y,
    input  logic             A,
    input  logic             B,
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             Y_q,
    output logic             chg,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] ne_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] run_nxt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // Zero-latency gate; X/Z on an operand propagates to Y unmasked.
    assign Y = ~(A ^ B);

    always_comb begin
        run_nxt = '0;
        if (Y) run_nxt = sat_inc(run_len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q     <= 1'b0;
            chg     <= 1'b0;
            eq_cnt  <= '0;
            ne_cnt  <= '0;
            run_len <= '0;
            max_run <= '0;
        end else begin
            Y_q <= Y;
            chg <= (Y != Y_q);
            // clr drops the current sample as well as the history.
            if (clr) begin
                eq_cnt  <= '0;
                ne_cnt  <= '0;
                run_len <= '0;
                max_run <= '0;
            end else begin
                if (Y) eq_cnt <= sat_inc(eq_cnt);
                else   ne_cnt <= sat_inc(ne_cnt);
                run_len <= run_nxt;
                max_run <= (run_nxt > max_run) ? run_nxt : max_run;
            end
        end
    end

endmodule

// File: tb/tb_ex_nor_gate.sv
// Bench for ex_nor_gate: truth table, directed multi-cycle sequences and a
// randomized run, checked against a sample-history model at two counter widths.
module tb_ex_nor_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;

    logic       y8, yq8, chg8;
    logic [7:0] eq8, ne8, run8, max8;
    logic       y2, yq2, chg2;
    logic [1:0] eq2, ne2, run2, max2;

    int checks = 0;
    int errors = 0;

    // Reference model: every sample since the last rst/clr, plus Y_q/chg.
    bit hist[$];
    bit yq_m  = 1'b0;
    bit chg_m = 1'b0;

    typedef struct {
        bit a;
        bit b;
        bit y;
    } tt_vec_t;
    tt_vec_t tt[4];

    always #5 clk = ~clk;

    ex_nor_gate #(.CNT_W(8)) dut8 (
        .Y(y8), .A(a), .B(b), .clk(clk), .rst(rst), .clr(clr),
        .Y_q(yq8), .chg(chg8), .eq_cnt(eq8), .ne_cnt(ne8),
        .run_len(run8), .max_run(max8)
    );

    ex_nor_gate #(.CNT_W(2)) dut2 (
        .Y(y2), .A(a), .B(b), .clk(clk), .rst(rst), .clr(clr),
        .Y_q(yq2), .chg(chg2), .eq_cnt(eq2), .ne_cnt(ne2),
        .run_len(run2), .max_run(max2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int min2(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Statistics derived from the raw sample history, then clipped.
    task automatic model_stats(input int sat, output int eq, output int ne,
                               output int run, output int mx);
        eq = 0; ne = 0; run = 0; mx = 0;
        foreach (hist[i]) begin
            if (hist[i]) begin
                eq++;
                run++;
            end else begin
                ne++;
                run = 0;
            end
            if (run > mx) mx = run;
        end
        eq  = min2(eq, sat);
        ne  = min2(ne, sat);
        run = min2(run, sat);
        mx  = min2(mx, sat);
    endtask

    task automatic check_all(input string tag);
        int eq, ne, run, mx;
        bit y_exp;
        y_exp = (a == b);
        chk({tag, ".Y8"}, int'(y8), int'(y_exp));
        chk({tag, ".Y2"}, int'(y2), int'(y_exp));
        chk({tag, ".Y_q8"}, int'(yq8), int'(yq_m));
        chk({tag, ".Y_q2"}, int'(yq2), int'(yq_m));
        chk({tag, ".chg8"}, int'(chg8), int'(chg_m));
        chk({tag, ".chg2"}, int'(chg2), int'(chg_m));
        model_stats(255, eq, ne, run, mx);
        chk({tag, ".eq8"}, int'(eq8), eq);
        chk({tag, ".ne8"}, int'(ne8), ne);
        chk({tag, ".run8"}, int'(run8), run);
        chk({tag, ".max8"}, int'(max8), mx);
        model_stats(3, eq, ne, run, mx);
        chk({tag, ".eq2"}, int'(eq2), eq);
        chk({tag, ".ne2"}, int'(ne2), ne);
        chk({tag, ".run2"}, int'(run2), run);
        chk({tag, ".max2"}, int'(max2), mx);
    endtask

    // Called at a falling edge: drive, take one rising edge, return at the
    // next falling edge. An optional glitch toggles A between edges.
    task automatic step(input bit sa, input bit sb, input bit sr, input bit sc,
                        input bit glitch = 1'b0);
        bit y;
        a = sa; b = sb; rst = sr; clr = sc;
        if (glitch) begin
            #1 a = ~sa;
            #2 a = sa;
        end
        @(posedge clk);
        y = (sa == sb);
        if (sr) begin
            hist.delete();
            yq_m  = 1'b0;
            chg_m = 1'b0;
        end else begin
            chg_m = (y != yq_m);
            yq_m  = y;
            if (sc) hist.delete();
            else    hist.push_back(y);
        end
        @(negedge clk);
    endtask

    initial begin
        tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b1};
        tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b0};
        tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b1};

        // Combinational truth table, 5 ns apart, checked 1 ns after change.
        for (int i = 0; i < 4; i++) begin
            a = tt[i].a;
            b = tt[i].b;
            #1;
            chk($sformatf("tt%0d.Y8", i), int'(y8), int'(tt[i].y));
            chk($sformatf("tt%0d.Y2", i), int'(y2), int'(tt[i].y));
            #4;
        end

        @(negedge clk);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        check_all("reset");
        chk("reset.eq8", int'(eq8), 0);
        chk("reset.Y_q8", int'(yq8), 0);

        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        check_all("eq5");
        chk("eq5.eq8", int'(eq8), 5);
        chk("eq5.ne8", int'(ne8), 0);
        chk("eq5.run8", int'(run8), 5);
        chk("eq5.max8", int'(max8), 5);
        chk("eq5.Y_q8", int'(yq8), 1);

        // Pattern Y = 1,1,1,0,1,1 from reset; chg checked every edge.
        step(0, 1, 1, 0);
        step(1, 1, 0, 0); check_all("pat0");
        step(0, 0, 0, 0); check_all("pat1");
        step(1, 1, 0, 0); check_all("pat2");
        step(1, 0, 0, 0); check_all("pat3");
        step(1, 1, 0, 0); check_all("pat4");
        step(0, 0, 0, 0); check_all("pat5");
        chk("pat.run8", int'(run8), 2);
        chk("pat.max8", int'(max8), 3);
        chk("pat.eq8", int'(eq8), 5);
        chk("pat.ne8", int'(ne8), 1);
        step(0, 0, 0, 0);
        chk("pat.chg_settle", int'(chg8), 0);

        // Saturation at CNT_W=2.
        step(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check_all("sat");
        chk("sat.eq2", int'(eq2), 3);
        chk("sat.run2", int'(run2), 3);
        step(0, 1, 0, 0);
        check_all("sat_break");
        chk("sat_break.run2", int'(run2), 0);
        chk("sat_break.max2", int'(max2), 3);

        // clr mid-run, then rst together with clr.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        check_all("clr");
        chk("clr.eq8", int'(eq8), 0);
        chk("clr.max8", int'(max8), 0);
        chk("clr.Y_q8", int'(yq8), 1);
        step(1, 1, 0, 0);
        check_all("post_clr");
        step(0, 1, 0, 1);
        chk("clr2.Y_q8", int'(yq8), 0);
        step(1, 1, 1, 1);
        check_all("rst_clr");
        chk("rst_clr.Y_q8", int'(yq8), 0);
        chk("rst_clr.eq8", int'(eq8), 0);

        // Randomized traffic with occasional rst/clr and inter-edge glitches.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 7) == 0));
            check_all($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
